// File: rtl/icache_pkg.sv
// icache_pkg: shared types and width helpers for the direct-mapped I-cache.
//   icache_state   - refill FSM state encoding (IDLE, REQ, WAIT, RESP)
//   offset_w_f     - word-offset width for a given line size
//   index_w_f      - index width for a given number of lines
//   tag_w_f        - tag width left over once the byte, word and index fields are removed
//   OFFSET_W, INDEX_W, TAG_W - widths for the default geometry
package icache_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_LINES  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } icache_state;

    function automatic int offset_w_f(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w_f(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Two low address bits select a byte within the word and are never stored.
    function automatic int tag_w_f(input int xlen, input int line_words, input int num_lines);
        return xlen - 2 - $clog2(line_words) - $clog2(num_lines);
    endfunction

    localparam int OFFSET_W = offset_w_f(DEF_LINE_WORDS);
    localparam int INDEX_W  = index_w_f(DEF_NUM_LINES);
    localparam int TAG_W    = tag_w_f(DEF_XLEN, DEF_LINE_WORDS, DEF_NUM_LINES);

endpackage

// File: rtl/icache_store.sv
// icache_store: tag, valid and data arrays of the direct-mapped I-cache.
//   clk, reset_n   - clock, asynchronous active-low reset (clears valid bits only)
//   rd_index_i/rd_word_i -> rd_valid_o, rd_tag_o, rd_data_o : combinational read
//   wr_en_i, wr_index_i, wr_word_i, wr_data_i : synchronous single-word write
//   tag_wr_i, tag_data_i : write the tag of line wr_index_i
//   set_valid_i    - mark line wr_index_i valid
//   clear_all_i    - clear every valid bit (wins over set_valid_i)
module icache_store
    import icache_pkg::*;
#(
    parameter int  XLEN       = DEF_XLEN,
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    parameter int  NUM_LINES  = DEF_NUM_LINES,
    localparam int OFF_W      = offset_w_f(LINE_WORDS),
    localparam int IDX_W      = index_w_f(NUM_LINES),
    localparam int TG_W       = tag_w_f(XLEN, LINE_WORDS, NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_index_i,
    input  logic [OFF_W-1:0] rd_word_i,
    output logic             rd_valid_o,
    output logic [TG_W-1:0]  rd_tag_o,
    output logic [XLEN-1:0]  rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_index_i,
    input  logic [OFF_W-1:0] wr_word_i,
    input  logic [XLEN-1:0]  wr_data_i,
    input  logic             tag_wr_i,
    input  logic [TG_W-1:0]  tag_data_i,
    input  logic             set_valid_i,
    input  logic             clear_all_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TG_W-1:0]      tag_q  [NUM_LINES];
    logic [XLEN-1:0]      data_q [NUM_LINES][LINE_WORDS];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_word_i];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (set_valid_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset so they can map onto RAM;
    // the valid bits alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
        end
        if (tag_wr_i) begin
            tag_q[wr_index_i] <= tag_data_i;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
//   clk, reset_n                  - clock, asynchronous active-low reset
//   cpu_req_valid/ready/addr      - fetch request (byte address, bits [1:0] ignored)
//   cpu_rsp_valid/data            - one-cycle response pulse with the instruction word
//   invalidate                    - fence.i: clear all valid bits
//   mem_req_valid/ready/addr      - single-word refill read request
//   mem_rsp_valid/data            - refill read data
// Hits answer on the cycle after acceptance; misses refill the whole line
// word 0 upward, one outstanding read at a time, then answer from RESP.
module icache_dm
    import icache_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cpu_req_valid,
    output logic            cpu_req_ready,
    input  logic [XLEN-1:0] cpu_req_addr,
    output logic            cpu_rsp_valid,
    output logic [XLEN-1:0] cpu_rsp_data,
    input  logic            invalidate,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data
);

    localparam int WORD_OFF_W = offset_w_f(LINE_WORDS);
    localparam int LINE_IDX_W = index_w_f(NUM_LINES);
    localparam int LINE_TAG_W = tag_w_f(XLEN, LINE_WORDS, NUM_LINES);

    icache_state           state_q;
    logic [LINE_TAG_W-1:0] tag_q;
    logic [LINE_IDX_W-1:0] index_q;
    logic [WORD_OFF_W-1:0] word_q;
    logic [WORD_OFF_W-1:0] cnt_q;
    logic                  inval_pend_q;
    logic                  rsp_valid_q;
    logic [XLEN-1:0]       rsp_data_q;
    logic                  mem_req_valid_q;
    logic [XLEN-1:0]       mem_req_addr_q;

    logic [LINE_TAG_W-1:0] req_tag;
    logic [LINE_IDX_W-1:0] req_index;
    logic [WORD_OFF_W-1:0] req_word;
    logic [WORD_OFF_W-1:0] cnt_next;
    logic                  rd_valid;
    logic [LINE_TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]       rd_data;
    logic                  hit;
    logic                  fill_beat;
    logic                  fill_last;
    logic                  unused_addr_bits;

    assign req_tag          = cpu_req_addr[XLEN-1 -: LINE_TAG_W];
    assign req_index        = cpu_req_addr[2+WORD_OFF_W +: LINE_IDX_W];
    assign req_word         = cpu_req_addr[2 +: WORD_OFF_W];
    assign unused_addr_bits = ^cpu_req_addr[1:0];
    assign cnt_next         = cnt_q + WORD_OFF_W'(1);

    assign fill_beat = (state_q == WAIT) && mem_rsp_valid;
    assign fill_last = fill_beat && (cnt_q == {WORD_OFF_W{1'b1}});
    assign hit       = rd_valid && (rd_tag == req_tag);

    // The read port looks up the incoming fetch in IDLE and the requested
    // word of the line being filled otherwise.
    icache_store #(
        .XLEN       (XLEN),
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_store (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_index_i  ((state_q == IDLE) ? req_index : index_q),
        .rd_word_i   ((state_q == IDLE) ? req_word : word_q),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (fill_beat),
        .wr_index_i  (index_q),
        .wr_word_i   (cnt_q),
        .wr_data_i   (mem_rsp_data),
        .tag_wr_i    (fill_last),
        .tag_data_i  (tag_q),
        // An invalidate seen at any point of this refill keeps the line invalid.
        .set_valid_i (fill_last && !inval_pend_q && !invalidate),
        .clear_all_i (invalidate)
    );

    assign cpu_req_ready = (state_q == IDLE);
    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_data  = rsp_data_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;

    // NOTE: every register here is updated with non-blocking assignments so
    // all of them see the pre-edge values of each other.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            tag_q           <= '0;
            index_q         <= '0;
            word_q          <= '0;
            cnt_q           <= '0;
            inval_pend_q    <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req_valid) begin
                        if (hit) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rd_data;
                        end else begin
                            tag_q           <= req_tag;
                            index_q         <= req_index;
                            word_q          <= req_word;
                            cnt_q           <= '0;
                            inval_pend_q    <= 1'b0;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {req_tag, req_index, {WORD_OFF_W{1'b0}}, 2'b00};
                            state_q         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (invalidate) inval_pend_q <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (invalidate) inval_pend_q <= 1'b1;
                    if (mem_rsp_valid) begin
                        cnt_q <= cnt_next;
                        if (fill_last) begin
                            // The requested word may be the one arriving right now.
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= (cnt_q == word_q) ? mem_rsp_data : rd_data;
                            state_q     <= RESP;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {tag_q, index_q, cnt_next, 2'b00};
                            state_q         <= REQ;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed self-checking bench for icache_dm.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic [31:0] cpu_req_addr = '0;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_data;
    logic        invalidate = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;

    int          checks = 0;
    int          errors = 0;
    int          mem_acc_cnt = 0;
    logic [31:0] seen_addr [4];
    bit          serve_to;

    icache_dm dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_data  (cpu_rsp_data),
        .invalidate    (invalidate),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && mem_req_valid && mem_req_ready) mem_acc_cnt <= mem_acc_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one fetch for one cycle; returns on the falling edge after acceptance.
    task automatic issue(input logic [31:0] addr);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    // Answer a full line refill; word i returns val0+i. Records request addresses.
    task automatic serve_refill(input logic [31:0] val0);
        int n;
        serve_to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (mem_req_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (mem_req_valid !== 1'b1) begin
                serve_to = 1'b1;
                return;
            end
            seen_addr[i]  = mem_req_addr;
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = val0 + 32'(i);
            @(negedge clk);
            mem_rsp_valid = 1'b0;
        end
    endtask

    task automatic check_refill(input string name, input logic [31:0] base);
        checks++;
        if (serve_to !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: got no mem request within budget, required 4 requests", name);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen_addr[i] !== base + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL %s_addr%0d: got %h required %h", name, i, seen_addr[i], base + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cpu_req_ready); end
        checks++;
        if (cpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", cpu_rsp_valid); end
        checks++;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b required 0", mem_req_valid); end
        checks++;
        if (cpu_rsp_data !== 32'h0 || mem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data_addr: got %h/%h required 0/0", cpu_rsp_data, mem_req_addr);
        end
    endtask

    task automatic test_cold_miss;
        int acc0;
        acc0 = mem_acc_cnt;
        issue(32'h100);
        checks++;
        if (mem_req_valid !== 1'b1 || cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL cold_miss_start: got memv=%b rspv=%b rdy=%b required 1 0 0", mem_req_valid, cpu_rsp_valid, cpu_req_ready);
        end
        serve_refill(32'hA0);
        check_refill("cold", 32'h100);
        checks++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_data !== 32'hA0) begin
            errors++;
            $display("FAIL cold_rsp: got v=%b d=%h required v=1 d=000000a0", cpu_rsp_valid, cpu_rsp_data);
        end
        @(negedge clk);
        checks++;
        if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL cold_after_rsp: got v=%b rdy=%b required v=0 rdy=1", cpu_rsp_valid, cpu_req_ready);
        end
        checks++;
        if (mem_acc_cnt - acc0 !== 4) begin errors++; $display("FAIL cold_mem_count: got %0d required 4", mem_acc_cnt - acc0); end
    endtask

    task automatic test_hits;
        logic [31:0] addrs [3];
        logic [31:0] exp   [3];
        int          acc0;
        addrs[0] = 32'h104; addrs[1] = 32'h108; addrs[2] = 32'h10C;
        exp[0]   = 32'hA1;  exp[1]   = 32'hA2;  exp[2]   = 32'hA3;
        acc0 = mem_acc_cnt;
        for (int i = 0; i < 3; i++) begin
            cpu_req_valid = 1'b1;
            cpu_req_addr  = addrs[i];
            @(negedge clk);
            checks++;
            if (cpu_rsp_valid !== 1'b1 || cpu_rsp_data !== exp[i]) begin
                errors++;
                $display("FAIL hit_%0d: got v=%b d=%h required v=1 d=%h", i, cpu_rsp_valid, cpu_rsp_data, exp[i]);
            end
        end
        cpu_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rsp_valid !== 1'b0 || mem_acc_cnt - acc0 !== 0) begin
            errors++;
            $display("FAIL hit_tail: got v=%b memreqs=%0d required v=0 memreqs=0", cpu_rsp_valid, mem_acc_cnt - acc0);
        end
    endtask

    task automatic test_conflict;
        issue(32'h1100);
        checks++;
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL conflict_miss: got memv=%b required 1", mem_req_valid); end
        serve_refill(32'hB0);
        check_refill("conflict", 32'h1100);
        checks++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_data !== 32'hB0) begin
            errors++;
            $display("FAIL conflict_rsp: got v=%b d=%h required v=1 d=000000b0", cpu_rsp_valid, cpu_rsp_data);
        end
        @(negedge clk);
        issue(32'h100);
        checks++;
        if (mem_req_valid !== 1'b1 || cpu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL conflict_evict: got memv=%b rspv=%b required 1 0", mem_req_valid, cpu_rsp_valid);
        end
        serve_refill(32'hA0);
        check_refill("evict", 32'h100);
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit stable;
        stable = 1'b1;
        issue(32'h2008);
        for (int i = 0; i < 5; i++) begin
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000 || cpu_rsp_valid !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (stable !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000) begin
            errors++;
            $display("FAIL bp_stable: got memv=%b addr=%h stable=%b required 1 00002000 1", mem_req_valid, mem_req_addr, stable);
        end
        serve_refill(32'hC0);
        check_refill("bp", 32'h2000);
        checks++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_data !== 32'hC2) begin
            errors++;
            $display("FAIL bp_rsp: got v=%b d=%h required v=1 d=000000c2", cpu_rsp_valid, cpu_rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_invalidate;
        // Invalidate while idle: a line that hit before must now refill.
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        issue(32'h100);
        checks++;
        if (mem_req_valid !== 1'b1 || cpu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_idle_miss: got memv=%b rspv=%b required 1 0", mem_req_valid, cpu_rsp_valid);
        end
        serve_refill(32'hA0);
        check_refill("inv_idle", 32'h100);
        @(negedge clk);
        // Invalidate alongside an accepted hit: it still answers, the next lookup misses.
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h104;
        invalidate    = 1'b1;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        invalidate    = 1'b0;
        checks++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_data !== 32'hA1) begin
            errors++;
            $display("FAIL inv_concurrent_hit: got v=%b d=%h required v=1 d=000000a1", cpu_rsp_valid, cpu_rsp_data);
        end
        issue(32'h104);
        checks++;
        if (mem_req_valid !== 1'b1 || cpu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_concurrent_next: got memv=%b rspv=%b required 1 0", mem_req_valid, cpu_rsp_valid);
        end
        serve_refill(32'hA0);
        checks++;
        if (serve_to !== 1'b0 || cpu_rsp_data !== 32'hA1) begin
            errors++;
            $display("FAIL inv_concurrent_refill: got to=%b d=%h required 0 000000a1", serve_to, cpu_rsp_data);
        end
        @(negedge clk);
        // Invalidate mid-refill: word is returned but the line stays invalid.
        issue(32'h2004);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        serve_refill(32'hD0);
        check_refill("inv_mid", 32'h2000);
        checks++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_data !== 32'hD1) begin
            errors++;
            $display("FAIL inv_mid_rsp: got v=%b d=%h required v=1 d=000000d1", cpu_rsp_valid, cpu_rsp_data);
        end
        @(negedge clk);
        issue(32'h2004);
        checks++;
        if (mem_req_valid !== 1'b1 || cpu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_mid_refetch: got memv=%b rspv=%b required 1 0", mem_req_valid, cpu_rsp_valid);
        end
        serve_refill(32'hD0);
        check_refill("inv_mid_re", 32'h2000);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_refill;
        int n;
        // Line 0x2000 is valid here; a new tag for the same index misses.
        issue(32'h3000);
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got memv=%b required 1", mem_req_valid); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (cpu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || cpu_rsp_data !== 32'h0 ||
            mem_req_addr !== 32'h0 || cpu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_outputs: got rspv=%b memv=%b d=%h a=%h rdy=%b required 0 0 0 0 1",
                     cpu_rsp_valid, mem_req_valid, cpu_rsp_data, mem_req_addr, cpu_req_ready);
        end
        @(negedge clk);
        reset_n       = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hEE;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        checks++;
        if (cpu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_stray_rsp: got rspv=%b memv=%b rdy=%b required 0 0 1", cpu_rsp_valid, mem_req_valid, cpu_req_ready);
        end
        issue(32'h2004);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000 || cpu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_next_miss: got memv=%b a=%h rspv=%b required 1 00002000 0", mem_req_valid, mem_req_addr, cpu_rsp_valid);
        end
        serve_refill(32'hD0);
        checks++;
        if (serve_to !== 1'b0 || cpu_rsp_valid !== 1'b1 || cpu_rsp_data !== 32'hD1) begin
            errors++;
            $display("FAIL rst_refill_rsp: got to=%b v=%b d=%h required 0 1 000000d1", serve_to, cpu_rsp_valid, cpu_rsp_data);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_cold_miss;
        test_hits;
        test_conflict;
        test_backpressure;
        test_invalidate;
        test_reset_mid_refill;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
